// File: rtl/cg_pkg.sv
// Shared definitions for the conjugate-gradient phase sequencer: phase indices,
// FSM state encodings and the lane-count log2 helper.
package cg_pkg;

    localparam int NUM_PHASES = 8;

    localparam int PH_INIT_RR = 0;
    localparam int PH_MXV     = 1;
    localparam int PH_PAP     = 2;
    localparam int PH_ALPHA   = 3;
    localparam int PH_XR_UPD  = 4;
    localparam int PH_RR      = 5;
    localparam int PH_BETA    = 6;
    localparam int PH_P_UPD   = 7;

    // Phases that stream vector words; ALPHA and BETA are scalar divides.
    localparam logic [NUM_PHASES-1:0] VEC_PHASE_MASK = 8'b1011_0111;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_INIT_RR = 4'd1;
    localparam logic [3:0] ST_MXV     = 4'd2;
    localparam logic [3:0] ST_PAP     = 4'd3;
    localparam logic [3:0] ST_ALPHA   = 4'd4;
    localparam logic [3:0] ST_XR_UPD  = 4'd5;
    localparam logic [3:0] ST_RR      = 4'd6;
    localparam logic [3:0] ST_BETA    = 4'd7;
    localparam logic [3:0] ST_P_UPD   = 4'd8;
    localparam logic [3:0] ST_DONE    = 4'd9;

    // Phase states are encoded as phase index + 1.
    typedef enum logic [3:0] {
        S_IDLE    = ST_IDLE,
        S_INIT_RR = ST_INIT_RR,
        S_MXV     = ST_MXV,
        S_PAP     = ST_PAP,
        S_ALPHA   = ST_ALPHA,
        S_XR_UPD  = ST_XR_UPD,
        S_RR      = ST_RR,
        S_BETA    = ST_BETA,
        S_P_UPD   = ST_P_UPD,
        S_DONE    = ST_DONE
    } state_e;

    function automatic int log2_units(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) == n) r = i;
        end
        return r;
    endfunction

    function automatic logic [NUM_PHASES-1:0] phase_bit(input int k);
        return NUM_PHASES'(1) << k;
    endfunction

endpackage

// File: rtl/cg_phase_sequencer_vec_addr_gen.sv
// Vector read-address stream: emits 0..len-1 starting on the go cycle,
// stalls on request, then drops enable and holds the last address.
module vec_addr_gen #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  active,
    input  logic                  stall,
    input  logic [31:0]           len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  en
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  en_q;
    logic                  cur_en;

    // go overrides the registered state so word 0 appears in the go cycle itself.
    always_comb begin
        cur_addr  = go ? '0 : addr_q;
        cur_en    = go | en_q;
        last_addr = ADDR_WIDTH'(len - 32'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            en_q   <= 1'b0;
        end else if (!active && !go) begin
            en_q <= 1'b0;
        end else if (cur_en && !stall) begin
            if (cur_addr == last_addr) begin
                addr_q <= cur_addr;
                en_q   <= 1'b0;
            end else begin
                addr_q <= cur_addr + 1'b1;
                en_q   <= 1'b1;
            end
        end else begin
            addr_q <= cur_addr;
            en_q   <= cur_en;
        end
    end

    assign addr = cur_addr;
    assign en   = cur_en;

endmodule

// File: rtl/cg_phase_sequencer.sv
// Phase scheduler for one CG solve: issues per-phase go pulses, drives the
// shared vector address stream and waits on each phase's done.
module cg_phase_sequencer
    import cg_pkg::*;
#(
    parameter int NO_OF_UNITS = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int ITER_WIDTH  = 11,
    parameter int MAX_ITER    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           total,
    input  logic [7:0]            phase_done,
    input  logic                  converged,
    input  logic                  vec_stall,
    output logic [7:0]            phase_go,
    output logic [7:0]            phase_active,
    output logic [ADDR_WIDTH-1:0] vec_rd_addr,
    output logic                  vec_rd_en,
    output logic [ITER_WIDTH-1:0] iteration,
    output logic                  busy,
    output logic                  halt,
    output logic                  max_reached,
    output logic                  len_err,
    output logic [31:0]           cycle_count
);

    localparam int                    LOG2_UNITS = log2_units(NO_OF_UNITS);
    localparam logic [ITER_WIDTH-1:0] ITER_LAST  = ITER_WIDTH'(MAX_ITER - 1);

    state_e                  state;
    logic [NUM_PHASES-1:0]   go_q;
    logic [31:0]             len_q;
    logic [ITER_WIDTH-1:0]   iter_q;
    logic                    maxr_q;
    logic                    lerr_q;
    logic [31:0]             cyc_q;

    logic [3:0]              st_raw;
    logic [2:0]              ph_idx;
    logic                    in_phase;
    logic [NUM_PHASES-1:0]   active;
    logic                    done_acc;
    logic [32:0]             len_calc;
    logic [31:0]             len_new;
    logic [ADDR_WIDTH-1:0]   gen_addr;
    logic                    gen_en;
    logic                    vec_phase;

    always_comb begin
        st_raw    = state;
        in_phase  = (state != S_IDLE) && (state != S_DONE);
        ph_idx    = 3'(st_raw - 4'd1);
        active    = in_phase ? phase_bit(int'(ph_idx)) : '0;
        // A done on the go cycle (go_q still set) is deliberately not accepted.
        done_acc  = in_phase && (go_q == '0) && |(phase_done & active);
        len_calc  = {1'b0, total} + 33'(NO_OF_UNITS - 1);
        len_new   = 32'(len_calc >> LOG2_UNITS);
        vec_phase = |(active & VEC_PHASE_MASK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            go_q   <= '0;
            len_q  <= '0;
            iter_q <= '0;
            maxr_q <= 1'b0;
            lerr_q <= 1'b0;
            cyc_q  <= '0;
        end else begin
            go_q <= '0;
            if (in_phase && (cyc_q != '1)) cyc_q <= cyc_q + 32'd1;

            if (abort) begin
                state  <= S_IDLE;
                maxr_q <= 1'b0;
                lerr_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            len_q  <= len_new;
                            iter_q <= '0;
                            cyc_q  <= '0;
                            maxr_q <= 1'b0;
                            lerr_q <= 1'b0;
                            if (len_new == '0) begin
                                state  <= S_DONE;
                                lerr_q <= 1'b1;
                            end else begin
                                state <= S_INIT_RR;
                                go_q  <= phase_bit(PH_INIT_RR);
                            end
                        end
                    end
                    default: begin
                        if (done_acc) begin
                            case (state)
                                S_INIT_RR: begin state <= S_MXV;    go_q <= phase_bit(PH_MXV);    end
                                S_MXV:     begin state <= S_PAP;    go_q <= phase_bit(PH_PAP);    end
                                S_PAP:     begin state <= S_ALPHA;  go_q <= phase_bit(PH_ALPHA);  end
                                S_ALPHA:   begin state <= S_XR_UPD; go_q <= phase_bit(PH_XR_UPD); end
                                S_XR_UPD:  begin state <= S_RR;     go_q <= phase_bit(PH_RR);     end
                                S_RR: begin
                                    if (converged) begin
                                        state <= S_DONE;
                                    end else if (iter_q == ITER_LAST) begin
                                        state  <= S_DONE;
                                        maxr_q <= 1'b1;
                                    end else begin
                                        state <= S_BETA;
                                        go_q  <= phase_bit(PH_BETA);
                                    end
                                end
                                S_BETA:    begin state <= S_P_UPD;  go_q <= phase_bit(PH_P_UPD);  end
                                S_P_UPD: begin
                                    iter_q <= iter_q + 1'b1;
                                    state  <= S_MXV;
                                    go_q   <= phase_bit(PH_MXV);
                                end
                                default: state <= S_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    vec_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_vec_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .go     (|(go_q & VEC_PHASE_MASK)),
        .active (vec_phase),
        .stall  (vec_stall),
        .len    (len_q),
        .addr   (gen_addr),
        .en     (gen_en)
    );

    assign phase_go     = go_q;
    assign phase_active = active;
    assign vec_rd_addr  = gen_addr;
    assign vec_rd_en    = gen_en & vec_phase;
    assign iteration    = iter_q;
    assign busy         = in_phase;
    assign halt         = (state == S_DONE);
    assign max_reached  = maxr_q;
    assign len_err      = lerr_q;
    assign cycle_count  = cyc_q;

endmodule

// File: tb/tb_cg_phase_sequencer.sv
// Directed bench for cg_phase_sequencer: a per-cycle vector table plus
// hand-written sequences for iteration limit, zero length, abort and reset.
module tb_cg_phase_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] total;
    logic [7:0]  phase_done;
    logic        converged;
    logic        vec_stall;
    logic [7:0]  phase_go;
    logic [7:0]  phase_active;
    logic [31:0] vec_rd_addr;
    logic        vec_rd_en;
    logic [10:0] iteration;
    logic        busy;
    logic        halt;
    logic        max_reached;
    logic        len_err;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    cg_phase_sequencer #(
        .NO_OF_UNITS (8),
        .ADDR_WIDTH  (32),
        .ITER_WIDTH  (11),
        .MAX_ITER    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .total        (total),
        .phase_done   (phase_done),
        .converged    (converged),
        .vec_stall    (vec_stall),
        .phase_go     (phase_go),
        .phase_active (phase_active),
        .vec_rd_addr  (vec_rd_addr),
        .vec_rd_en    (vec_rd_en),
        .iteration    (iteration),
        .busy         (busy),
        .halt         (halt),
        .max_reached  (max_reached),
        .len_err      (len_err),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [7:0]  done;
        logic        conv;
        logic        stall;
        logic [7:0]  go;
        logic [7:0]  act;
        logic        en;
        logic        chk_addr;
        logic [31:0] addr;
        logic        busy;
        logic        halt;
        logic [10:0] iter;
    } vec_t;

    vec_t tbl[31];
    int   go_log[$];
    int   mxv_cnt;

    function automatic vec_t mk(input logic st, input logic [7:0] dn, input logic cv, input logic sl,
                                input logic [7:0] g, input logic [7:0] a, input logic e, input logic ca,
                                input logic [31:0] ad, input logic b, input logic h, input logic [10:0] it);
        vec_t v;
        v.start = st; v.done = dn; v.conv = cv; v.stall = sl;
        v.go = g; v.act = a; v.en = e; v.chk_addr = ca; v.addr = ad;
        v.busy = b; v.halt = h; v.iter = it;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " phase_go"},     32'(phase_go), 0);
        chk({tag, " phase_active"}, 32'(phase_active), 0);
        chk({tag, " vec_rd_addr"},  vec_rd_addr, 0);
        chk({tag, " vec_rd_en"},    32'(vec_rd_en), 0);
        chk({tag, " iteration"},    32'(iteration), 0);
        chk({tag, " busy"},         32'(busy), 0);
        chk({tag, " halt"},         32'(halt), 0);
        chk({tag, " max_reached"},  32'(max_reached), 0);
        chk({tag, " len_err"},      32'(len_err), 0);
        chk({tag, " cycle_count"},  cycle_count, 0);
    endtask

    // Returns done 3 cycles after every go until halt or the cycle budget expires.
    task automatic run_auto(input logic conv_val);
        int cnt;
        cnt = 0;
        go_log.delete();
        mxv_cnt = 0;
        converged = conv_val;
        for (int c = 0; c < 400; c++) begin
            if (halt) break;
            if (phase_go != 8'h00) begin
                for (int k = 0; k < 8; k++) if (phase_go[k]) go_log.push_back(k);
                if (phase_go[1]) mxv_cnt++;
                cnt = 0;
            end else begin
                cnt++;
            end
            phase_done = (cnt == 3) ? phase_active : 8'h00;
            tick();
        end
        phase_done = 8'h00;
        converged  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; total = '0;
        phase_done = '0; converged = 1'b0; vec_stall = 1'b0;

        //        st  done  cv sl   go     act    en ca addr b  h  it
        tbl[0]  = mk(1, 8'h00, 0, 0, 8'h01, 8'h01, 1, 1, 0, 1, 0, 0);
        tbl[1]  = mk(0, 8'h01, 0, 0, 8'h00, 8'h01, 1, 1, 1, 1, 0, 0);
        tbl[2]  = mk(0, 8'h02, 0, 1, 8'h00, 8'h01, 1, 1, 1, 1, 0, 0);
        tbl[3]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 1, 2, 1, 0, 0);
        tbl[4]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h01, 0, 1, 2, 1, 0, 0);
        tbl[5]  = mk(0, 8'h01, 0, 0, 8'h02, 8'h02, 1, 1, 0, 1, 0, 0);
        tbl[6]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h02, 1, 1, 1, 1, 0, 0);
        tbl[7]  = mk(0, 8'h02, 0, 0, 8'h04, 8'h04, 1, 1, 0, 1, 0, 0);
        tbl[8]  = mk(0, 8'h04, 0, 0, 8'h00, 8'h04, 1, 1, 1, 1, 0, 0);
        tbl[9]  = mk(0, 8'h04, 0, 0, 8'h08, 8'h08, 0, 0, 0, 1, 0, 0);
        tbl[10] = mk(0, 8'h00, 0, 0, 8'h00, 8'h08, 0, 0, 0, 1, 0, 0);
        tbl[11] = mk(0, 8'h08, 0, 0, 8'h10, 8'h10, 1, 1, 0, 1, 0, 0);
        tbl[12] = mk(0, 8'h10, 0, 0, 8'h00, 8'h10, 1, 1, 1, 1, 0, 0);
        tbl[13] = mk(0, 8'h10, 0, 0, 8'h20, 8'h20, 1, 1, 0, 1, 0, 0);
        tbl[14] = mk(0, 8'h00, 0, 0, 8'h00, 8'h20, 1, 1, 1, 1, 0, 0);
        tbl[15] = mk(0, 8'h20, 0, 0, 8'h40, 8'h40, 0, 0, 0, 1, 0, 0);
        tbl[16] = mk(0, 8'h20, 1, 0, 8'h00, 8'h40, 0, 0, 0, 1, 0, 0);
        tbl[17] = mk(0, 8'h40, 0, 0, 8'h80, 8'h80, 1, 1, 0, 1, 0, 0);
        tbl[18] = mk(0, 8'h00, 0, 0, 8'h00, 8'h80, 1, 1, 1, 1, 0, 0);
        tbl[19] = mk(0, 8'h80, 0, 0, 8'h02, 8'h02, 1, 1, 0, 1, 0, 1);
        tbl[20] = mk(1, 8'h00, 0, 0, 8'h00, 8'h02, 1, 1, 1, 1, 0, 1);
        tbl[21] = mk(0, 8'h02, 0, 0, 8'h04, 8'h04, 1, 1, 0, 1, 0, 1);
        tbl[22] = mk(0, 8'h00, 0, 0, 8'h00, 8'h04, 1, 1, 1, 1, 0, 1);
        tbl[23] = mk(0, 8'h04, 0, 0, 8'h08, 8'h08, 0, 0, 0, 1, 0, 1);
        tbl[24] = mk(0, 8'h00, 0, 0, 8'h00, 8'h08, 0, 0, 0, 1, 0, 1);
        tbl[25] = mk(0, 8'h08, 0, 0, 8'h10, 8'h10, 1, 1, 0, 1, 0, 1);
        tbl[26] = mk(0, 8'h00, 0, 0, 8'h00, 8'h10, 1, 1, 1, 1, 0, 1);
        tbl[27] = mk(0, 8'h10, 0, 0, 8'h20, 8'h20, 1, 1, 0, 1, 0, 1);
        tbl[28] = mk(0, 8'h00, 0, 0, 8'h00, 8'h20, 1, 1, 1, 1, 0, 1);
        tbl[29] = mk(0, 8'h20, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1);
        tbl[30] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk) reset = 1'b1;
        tick();
        chk_all_zero("post-reset idle");

        // total=20 -> len=3; stall, early and wrong-phase done, one full iteration
        total = 32'd20;
        for (int i = 0; i < 31; i++) begin
            start      = tbl[i].start;
            phase_done = tbl[i].done;
            converged  = tbl[i].conv;
            vec_stall  = tbl[i].stall;
            tick();
            chk($sformatf("row%0d phase_go", i),     32'(phase_go),     32'(tbl[i].go));
            chk($sformatf("row%0d phase_active", i), 32'(phase_active), 32'(tbl[i].act));
            chk($sformatf("row%0d vec_rd_en", i),    32'(vec_rd_en),    32'(tbl[i].en));
            if (tbl[i].chk_addr)
                chk($sformatf("row%0d vec_rd_addr", i), vec_rd_addr, tbl[i].addr);
            chk($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].busy));
            chk($sformatf("row%0d halt", i),      32'(halt),      32'(tbl[i].halt));
            chk($sformatf("row%0d iteration", i), 32'(iteration), 32'(tbl[i].iter));
        end
        start = 1'b0; phase_done = '0; converged = 1'b0; vec_stall = 1'b0;

        // total=64, converge on first RR; restart from DONE
        total = 32'd64;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_auto(1'b1);
        chk("conv go count", 32'(go_log.size()), 6);
        for (int i = 0; i < go_log.size() && i < 6; i++)
            chk($sformatf("conv go order %0d", i), 32'(go_log[i]), 32'(i));
        chk("conv halt",        32'(halt), 1);
        chk("conv busy",        32'(busy), 0);
        chk("conv iteration",   32'(iteration), 0);
        chk("conv cycle_count", cycle_count, 24);
        chk("conv max_reached", 32'(max_reached), 0);

        // never converge: iteration limit of 4
        total = 32'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_auto(1'b0);
        chk("maxit mxv entries", 32'(mxv_cnt), 4);
        chk("maxit iteration",   32'(iteration), 3);
        chk("maxit max_reached", 32'(max_reached), 1);
        chk("maxit halt",        32'(halt), 1);
        chk("maxit len_err",     32'(len_err), 0);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort from done halt",        32'(halt), 0);
        chk("abort from done max_reached", 32'(max_reached), 0);

        // zero-length solve
        total = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0 halt",     32'(halt), 1);
        chk("len0 len_err",  32'(len_err), 1);
        chk("len0 phase_go", 32'(phase_go), 0);
        chk("len0 busy",     32'(busy), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // abort mid-MXV, then restart
        total = 32'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        phase_done = 8'h01;
        tick();
        phase_done = 8'h00;
        chk("pre-abort mxv go", 32'(phase_go), 32'h02);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy",         32'(busy), 0);
        chk("abort phase_active", 32'(phase_active), 0);
        chk("abort halt",         32'(halt), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart phase_go",    32'(phase_go), 32'h01);
        chk("restart cycle_count", cycle_count, 0);
        tick();
        chk("restart cycle_count+1", cycle_count, 1);

        // asynchronous reset mid-MXV
        phase_done = 8'h01;
        tick();
        phase_done = 8'h00;
        tick();
        chk("pre-reset in mxv", 32'(phase_active), 32'h02);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(negedge clk) reset = 1'b1;
        tick();
        chk("after reset busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
